debug_ctrl: RTL

Parametrised debug controller between the UART (rx/tx byte interfaces) and the pipelined CPU. It decodes host command bytes. It loads program memory with words of configurable width. It runs the pipe continuously or one step at a time, with an optional PC breakpoint. After every run or step it streams a cycle count plus a pipe-state dump back to the host, byte by byte.

---
 rtl/debug_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/debug_ctrl.sv
// Debug controller between the UART byte interfaces and the pipelined CPU: loads program memory,
// runs or single-steps the pipe with an optional PC breakpoint, then streams a state dump.
module debug_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned DUMP_BYTES  = 320,
  parameter int unsigned CNT_W       = 32,
  parameter logic [7:0]  CMD_LOAD    = 8'h01,
  parameter logic [7:0]  CMD_RUN     = 8'h02,
  parameter logic [7:0]  CMD_STEP    = 8'h03,
  parameter logic [7:0]  CMD_SETBP   = 8'h04,
  parameter logic [7:0]  CMD_CLRBP   = 8'h05
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_done,
  input  logic                      i_tx_done,
  input  logic                      i_halt,
  input  logic [ADDR_W-1:0]         i_pc,
  input  logic [DUMP_BYTES*8-1:0]   i_dump_data,
  output logic                      o_step,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [INSTR_BYTES*8-1:0]  o_mem_data,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_start,
  output logic                      o_busy
);

  localparam int unsigned WordW    = INSTR_BYTES * 8;
  localparam int unsigned CntBytes = CNT_W / 8;
  localparam int unsigned BpBytes  = (ADDR_W + 7) / 8;
  localparam int unsigned Total    = CntBytes + DUMP_BYTES;
  localparam int unsigned IdxW     = $clog2(Total + 1);
  localparam int unsigned ColMax   = (INSTR_BYTES > BpBytes) ? INSTR_BYTES : BpBytes;
  localparam int unsigned BcW      = $clog2(ColMax + 1);

  typedef enum logic [2:0] {
    StIdle, StLdCnt, StLdData, StBpData, StRun, StStep, StDumpSend, StDumpWait
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bp_en_q, bp_en_d;
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [BcW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]        words_left_q, words_left_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WordW-1:0]  mem_data_q, mem_data_d;
  logic [IdxW-1:0]   dump_idx_q, dump_idx_d;
  logic              first_q, first_d;
  logic              stop;
  logic              step;
  logic [31:0]       idx32;
  logic [7:0]        tx_byte;

  // The breakpoint is masked on the first RUN cycle so a run can resume from it.
  assign stop = i_halt | (bp_en_q & ~first_q & (i_pc == bp_addr_q));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bp_en_d      = bp_en_q;
    bp_addr_d    = bp_addr_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;
    widx_d       = widx_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    dump_idx_d   = dump_idx_q;
    first_d      = first_q;
    step         = 1'b0;
    o_tx_start   = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d = StLdCnt;
          end else if (i_rx_data == CMD_RUN) begin
            state_d = StRun;
            cnt_d   = '0;
            first_d = 1'b1;
          end else if (i_rx_data == CMD_STEP) begin
            state_d = StStep;
          end else if (i_rx_data == CMD_SETBP) begin
            state_d    = StBpData;
            byte_cnt_d = '0;
          end else if (i_rx_data == CMD_CLRBP) begin
            bp_en_d = 1'b0;
          end
        end
      end
      StLdCnt: begin
        if (i_rx_done) begin
          if (i_rx_data == 8'd0) begin
            state_d = StIdle;
          end else begin
            state_d      = StLdData;
            words_left_d = i_rx_data;
            widx_d       = '0;
            cnt_d        = '0;
            byte_cnt_d   = '0;
            word_d       = '0;
          end
        end
      end
      StLdData: begin
        if (i_rx_done) begin
          word_d = WordW'({word_q, i_rx_data});
          if (byte_cnt_q == BcW'(INSTR_BYTES - 1)) begin
            byte_cnt_d   = '0;
            mem_we_d     = 1'b1;
            mem_addr_d   = widx_q;
            mem_data_d   = WordW'({word_q, i_rx_data});
            widx_d       = widx_q + 1'b1;
            words_left_d = words_left_q - 8'd1;
            if (words_left_q == 8'd1) state_d = StIdle;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StBpData: begin
        if (i_rx_done) begin
          // Shifting through the address register keeps only the low ADDR_W bits.
          bp_addr_d = ADDR_W'({bp_addr_q, i_rx_data});
          if (byte_cnt_q == BcW'(BpBytes - 1)) begin
            bp_en_d = 1'b1;
            state_d = StIdle;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        first_d = 1'b0;
        if (stop) begin
          state_d    = StDumpSend;
          dump_idx_d = '0;
        end else begin
          step = 1'b1;
        end
      end
      StStep: begin
        step       = ~i_halt;
        dump_idx_d = '0;
        state_d    = StDumpSend;
      end
      StDumpSend: begin
        o_tx_start = 1'b1;
        state_d    = StDumpWait;
      end
      StDumpWait: begin
        if (i_tx_done) begin
          if (dump_idx_q == IdxW'(Total - 1)) begin
            state_d = StIdle;
          end else begin
            dump_idx_d = dump_idx_q + 1'b1;
            state_d    = StDumpSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (step && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter bytes go out MSB first, then the live pipe-state bytes in ascending order.
  always_comb begin
    idx32 = 32'(dump_idx_q);
    if (idx32 < CntBytes) tx_byte = 8'(cnt_q >> (8 * (CntBytes - 1 - idx32)));
    else                  tx_byte = 8'(i_dump_data >> (8 * (idx32 - CntBytes)));
    o_tx_data = (state_q == StDumpSend || state_q == StDumpWait) ? tx_byte : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bp_en_q      <= 1'b0;
      bp_addr_q    <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      widx_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      dump_idx_q   <= '0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bp_en_q      <= bp_en_d;
      bp_addr_q    <= bp_addr_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      widx_q       <= widx_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      dump_idx_q   <= dump_idx_d;
      first_q      <= first_d;
    end
  end

  assign o_step     = step;
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_busy     = (state_q != StIdle);

endmodule
